// File: rtl/haraka_pkg.sv
// Shared Haraka-S datapath definitions.
// Holds the block/word geometry and the serializer FSM state type. The 64-to-256
// deserializer is built from the same constants, so the two stay in step.
package haraka_pkg;

    localparam int unsigned BLOCK_W         = 256;
    localparam int unsigned WORD_W          = 64;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

endpackage

// File: rtl/block_serializer.sv
// block_serializer
// Splits one INWIDTH-bit block into NWORDS words of OUTWIDTH bits. Word 0
// (bits [OUTWIDTH-1:0]) goes out first. The number of words sent can be cut
// short for a partial final block.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   block on in_data is valid
//   in_ready   block accepted when in_valid && in_ready at a clk edge
//   in_data    block to serialize
//   in_nwords  words to emit, 1..NWORDS; 0 (or anything above NWORDS) means NWORDS
//   in_last    block is the last of the message
//   out_valid  out_data holds a word
//   out_ready  sink accepts the word
//   out_data   current word
//   out_last   current word is the final word of the final block
//   busy       a block is loaded and not fully sent
module block_serializer
    import haraka_pkg::*;
#(
    parameter int unsigned INWIDTH  = BLOCK_W,
    parameter int unsigned OUTWIDTH = WORD_W,
    localparam int unsigned NWORDS  = INWIDTH / OUTWIDTH,
    localparam int unsigned CW      = $clog2(NWORDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INWIDTH-1:0]  in_data,
    input  logic [CW-1:0]       in_nwords,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTWIDTH-1:0] out_data,
    output logic                out_last,
    output logic                busy
);

    localparam logic [CW-1:0] NWORDS_C = CW'(NWORDS);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    ser_state_t         r_state;
    ser_state_t         w_state_next;
    logic [INWIDTH-1:0] r_shreg;
    logic [CW-1:0]      r_remaining;
    logic               r_last;

    logic               w_out_hs;
    logic               w_last_word;
    logic               w_load;
    logic [CW-1:0]      w_nwords;

    // Handshake is taken from the state directly rather than from out_valid so
    // that in_ready does not loop back through the output process.
    assign w_out_hs    = (r_state == SEND) && out_ready;
    assign w_last_word = (r_remaining == ONE_C);
    assign w_load      = in_valid && in_ready;
    assign w_nwords    = ((in_nwords == '0) || (in_nwords > NWORDS_C)) ? NWORDS_C : in_nwords;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                // A waiting block on the final handshake keeps us in SEND (no bubble).
                if (w_out_hs && w_last_word && !in_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        out_valid = (r_state == SEND);
        busy      = (r_state == SEND);
        in_ready  = (r_state == IDLE) || (w_out_hs && w_last_word);
        out_data  = r_shreg[OUTWIDTH-1:0];
        out_last  = r_last && w_last_word;
    end

    // Shift register and word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg     <= '0;
            r_remaining <= '0;
            r_last      <= 1'b0;
        end else if (w_load) begin
            r_shreg     <= in_data;
            r_remaining <= w_nwords;
            r_last      <= in_last;
        end else if (w_out_hs) begin
            r_shreg     <= r_shreg >> OUTWIDTH;
            r_remaining <= r_remaining - ONE_C;
        end
    end

endmodule
